// File: rtl/nibble_serial_adder.sv
// Multi-cycle DATA_W adder: one SLICE_W slice per clock, LSB first, behind a start/busy/done handshake.
// Latency N = DATA_W/SLICE_W cycles from accepted start to done; start while busy is ignored.
// Optional ovf output enabled by defining ADDER_OVF_EN.
module nibble_serial_adder #(
    parameter int DATA_W  = 16,
    parameter int SLICE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sum,
    output logic              cout
`ifdef ADDER_OVF_EN
    ,
    output logic              ovf
`endif
);

    localparam int N     = DATA_W / SLICE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                carry_q, carry_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                cout_q, cout_d;
    logic                done_q, done_d;
`ifdef ADDER_OVF_EN
    logic                ovf_q, ovf_d;
`endif

    logic [SLICE_W-1:0]  a_sl;
    logic [SLICE_W-1:0]  b_sl;
    logic [SLICE_W:0]    slice_res;
    int                  slice_ofs;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        done_d    = 1'b0;
`ifdef ADDER_OVF_EN
        ovf_d     = ovf_q;
`endif
        slice_ofs = int'(idx_q) * SLICE_W;
        a_sl      = a_q[slice_ofs +: SLICE_W];
        b_sl      = b_q[slice_ofs +: SLICE_W];
        slice_res = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE_W+1)'(carry_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[slice_ofs +: SLICE_W] = slice_res[SLICE_W-1:0];
                carry_d = slice_res[SLICE_W];
                if (idx_q == IDX_W'(N-1)) begin
                    sum_d   = acc_d;
                    cout_d  = slice_res[SLICE_W];
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
`ifdef ADDER_OVF_EN
                    // Same-sign operands giving an opposite-sign result, i.e. carry into MSB != carry out.
                    ovf_d = (a_sl[SLICE_W-1] ~^ b_sl[SLICE_W-1])
                          & (slice_res[SLICE_W-1] ^ a_sl[SLICE_W-1]);
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
`ifdef ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed literal cases plus randomized traffic against a cycle-count model.
module tb_nibble_serial_adder;

    localparam int DW = 16;
    localparam int SW = 4;
    localparam int N  = DW / SW;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cin   = 1'b0;
    logic [DW-1:0] a     = '0;
    logic [DW-1:0] b     = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] sum;
    logic          cout;
`ifdef ADDER_OVF_EN
    logic          ovf;
`endif

    nibble_serial_adder #(.DATA_W(DW), .SLICE_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted request yields a+b+cin exactly N edges later; requests while pending are dropped.
    int            rem      = 0;
    logic [DW:0]   pend     = '0;
    logic [DW-1:0] pa       = '0;
    logic [DW-1:0] pb       = '0;
    logic          exp_busy = 1'b0;
    logic          exp_done = 1'b0;
    logic [DW-1:0] exp_sum  = '0;
    logic          exp_cout = 1'b0;
    logic          exp_ovf  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            rem      = 0;
            exp_done = 1'b0;
            exp_sum  = '0;
            exp_cout = 1'b0;
            exp_ovf  = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    exp_done = 1'b1;
                    {exp_cout, exp_sum} = pend;
                    exp_ovf = (pa[DW-1] == pb[DW-1]) && (pend[DW-1] != pa[DW-1]);
                end
            end else if (start) begin
                rem  = N;
                pend = {1'b0, a} + {1'b0, b} + (DW+1)'(cin);
                pa   = a;
                pb   = b;
            end
        end
        exp_busy = (rem > 0);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            check("sum",  32'(sum),  32'(exp_sum));
            check("cout", 32'(cout), 32'(exp_cout));
`ifdef ADDER_OVF_EN
            check("ovf",  32'(ovf),  32'(exp_ovf));
`endif
        end
    end

    task automatic issue(input logic [DW-1:0] ta, input logic [DW-1:0] tb_v, input logic tc);
        a     = ta;
        b     = tb_v;
        cin   = tc;
        start = 1'b1;
    endtask

    // Called right after issue(); returns at the negedge where done is observed.
    task automatic wait_done(input string nm, input logic [DW-1:0] es, input logic ec, input logic eo);
        int lat  = 0;
        int bcnt = 0;
        @(negedge clk);
        start = 1'b0;
        a     = DW'($urandom);
        b     = DW'($urandom);
        cin   = 1'($urandom);
        if (busy === 1'b1) bcnt++;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy === 1'b1) bcnt++;
        end
        check({nm, "_latency"},  32'(lat),  32'(N));
        check({nm, "_busy_cyc"}, 32'(bcnt), 32'(N));
        check({nm, "_sum"},      32'(sum),  32'(es));
        check({nm, "_cout"},     32'(cout), 32'(ec));
        check({nm, "_model"},    32'(exp_sum), 32'(es));
`ifdef ADDER_OVF_EN
        check({nm, "_ovf"},      32'(ovf),  32'(eo));
`else
        if (eo) begin end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1);
    end

    initial begin
        int dcnt;
        logic [DW-1:0] dsum;

        repeat (2) @(negedge clk);
        chk_en = 1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'h1234, 16'h4321, 1'b0);
        wait_done("add_5555", 16'h5555, 1'b0, 1'b0);
        @(negedge clk);
        issue(16'hFFFF, 16'h0000, 1'b1);
        wait_done("ripple", 16'h0000, 1'b1, 1'b0);
`ifdef ADDER_OVF_EN
        @(negedge clk);
        issue(16'h7FFF, 16'h0001, 1'b0);
        wait_done("ovf_pos", 16'h8000, 1'b0, 1'b1);
        @(negedge clk);
        issue(16'h8000, 16'h8000, 1'b0);
        wait_done("ovf_neg", 16'h0000, 1'b1, 1'b1);
`endif

        // Second request two edges after acceptance must be dropped.
        @(negedge clk);
        issue(16'h0001, 16'h0001, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        issue(16'hAAAA, 16'h5555, 1'b0);
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        dsum = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcnt++;
                dsum = sum;
            end
        end
        check("ignored_done_cnt", 32'(dcnt), 32'd1);
        check("ignored_sum",      32'(dsum), 32'h0002);

        // Back-to-back: next start raised in the done cycle.
        issue(16'h0F0F, 16'h0101, 1'b0);
        wait_done("b2b_first", 16'h1010, 1'b0, 1'b0);
        issue(16'h00FF, 16'h0001, 1'b0);
        wait_done("b2b_second", 16'h0100, 1'b0, 1'b0);

        // Abort at idx=2 after a prior result of 0x5555.
        @(negedge clk);
        issue(16'h1234, 16'h4321, 1'b0);
        wait_done("pre_abort", 16'h5555, 1'b0, 1'b0);
        @(negedge clk);
        issue(16'hFFFF, 16'hFFFF, 1'b1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_hold_sum", 32'(sum), 32'h5555);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_sum",  32'(sum),  32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        check("abort_no_done", 32'(dcnt), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 4))
                0: a = 16'hFFFF;
                1: a = 16'h7FFF;
                2: a = 16'h8000;
                default: a = DW'($urandom);
            endcase
            b   = ($urandom_range(0, 3) == 0) ? 16'h0001 : DW'($urandom);
            cin = 1'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (N + 2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
